// File: rtl/mii_rx_frame_parser_pkg.sv
// Shared constants for the MII receive path: FSM encoding, CRC-32 constants,
// error-flag bit positions and the preamble/SFD nibble values.
package mii_rx_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_PREAMBLE = 2'd1;
    localparam state_t ST_DATA     = 2'd2;
    localparam state_t ST_DROP     = 2'd3;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    localparam int ERR_CRC  = 0;
    localparam int ERR_RXER = 1;
    localparam int ERR_ODD  = 2;
    localparam int ERR_LEN  = 3;

    localparam logic [3:0] PRE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB = 4'hD;

    localparam logic [10:0] LEN_SAT = 11'h7FF;

endpackage

// File: rtl/mii_rx_frame_parser_if.sv
// MII receive nibble bus (PHY -> MAC) and the parsed byte stream plus
// per-frame status produced by the frame parser.
interface mii_rx_if;
    logic       mac_mii_rxdv;
    logic       mac_mii_rxer;
    logic [3:0] mac_mii_rxd;

    modport master (output mac_mii_rxdv, output mac_mii_rxer, output mac_mii_rxd);
    modport slave  (input  mac_mii_rxdv, input  mac_mii_rxer, input  mac_mii_rxd);
endinterface

interface rx_stream_if;
    logic        rx_tvalid;
    logic [7:0]  rx_tdata;
    logic        rx_tlast;
    logic        rx_tuser;
    logic        frame_done;
    logic        frame_good;
    logic [3:0]  err_flags;
    logic [10:0] frame_len;

    modport master (output rx_tvalid, output rx_tdata, output rx_tlast, output rx_tuser,
                    output frame_done, output frame_good, output err_flags, output frame_len);
    modport slave  (input  rx_tvalid, input  rx_tdata, input  rx_tlast, input  rx_tuser,
                    input  frame_done, input  frame_good, input  err_flags, input  frame_len);
endinterface

// File: rtl/mii_rx_frame_parser_crc32.sv
// Combinational byte-wide step of the reflected Ethernet CRC-32, built as an
// eight-stage chain of single-bit LFSR shifts.
module eth_crc32_d8
    import mii_rx_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    logic [31:0] stage [9];

    assign stage[0] = crc ^ {24'd0, data};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign stage[gi+1] = stage[gi][0] ? ((stage[gi] >> 1) ^ CRC_POLY)
                                              : (stage[gi] >> 1);
        end
    endgenerate

    assign crc_next = stage[8];

endmodule

// File: rtl/mii_rx_frame_parser.sv
// MII receive frame parser: preamble/SFD detection, nibble-to-byte packing,
// CRC/length checking, optional FCS stripping via a byte delay line.
module mii_rx_frame_parser
    import mii_rx_pkg::*;
#(
    parameter int MIN_LEN   = 64,
    parameter int MAX_LEN   = 1518,
    parameter int STRIP_FCS = 1
) (
    input  logic         mac_mii_rxc,
    input  logic         rstn,
    mii_rx_if.slave      mii,
    rx_stream_if.master  rx
);

    // Holding back four extra bytes lets the FCS be dropped once rxdv falls.
    localparam int          DEPTH   = (STRIP_FCS != 0) ? 5 : 1;
    localparam logic [2:0]  DEPTH_F = 3'(DEPTH);
    localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L   = 11'(MAX_LEN);

    state_t      state_reg;
    logic        phase_reg;
    logic [3:0]  low_nib_reg;
    logic [31:0] crc_reg;
    logic [31:0] crc_next;
    logic [10:0] len_reg;
    logic        rxer_reg;
    logic [7:0]  dl_reg [DEPTH];
    logic [2:0]  fill_reg;

    logic        tvalid_reg;
    logic [7:0]  tdata_reg;
    logic        tlast_reg;
    logic        tuser_reg;
    logic        done_reg;
    logic        good_reg;
    logic [3:0]  err_reg;
    logic [10:0] flen_reg;

    logic [7:0]  byte_now;
    logic        push;
    logic        line_full;
    logic [3:0]  err_next;

    assign byte_now  = {mii.mac_mii_rxd, low_nib_reg};
    assign push      = (state_reg == ST_DATA) && mii.mac_mii_rxdv && phase_reg;
    assign line_full = (fill_reg == DEPTH_F);

    eth_crc32_d8 u_crc (
        .crc      (crc_reg),
        .data     (byte_now),
        .crc_next (crc_next)
    );

    // Status as it will be reported if this edge turns out to be end of frame.
    always_comb begin
        err_next           = '0;
        err_next[ERR_LEN]  = (len_reg < MIN_L) || (len_reg > MAX_L) || !line_full;
        err_next[ERR_ODD]  = phase_reg;
        err_next[ERR_RXER] = rxer_reg | mii.mac_mii_rxer;
        err_next[ERR_CRC]  = (crc_reg != CRC_RESIDUE);
    end

    always_ff @(posedge mac_mii_rxc) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) dl_reg[i] <= '0;
        end else if (push) begin
            for (int i = DEPTH - 1; i > 0; i--) dl_reg[i] <= dl_reg[i-1];
            dl_reg[0] <= byte_now;
        end
    end

    always_ff @(posedge mac_mii_rxc) begin
        if (!rstn) begin
            state_reg   <= ST_IDLE;
            phase_reg   <= 1'b0;
            low_nib_reg <= '0;
            crc_reg     <= CRC_INIT;
            len_reg     <= '0;
            rxer_reg    <= 1'b0;
            fill_reg    <= '0;
            tvalid_reg  <= 1'b0;
            tdata_reg   <= '0;
            tlast_reg   <= 1'b0;
            tuser_reg   <= 1'b0;
            done_reg    <= 1'b0;
            good_reg    <= 1'b0;
            err_reg     <= '0;
            flen_reg    <= '0;
        end else begin
            tvalid_reg <= 1'b0;
            tdata_reg  <= '0;
            tlast_reg  <= 1'b0;
            tuser_reg  <= 1'b0;
            done_reg   <= 1'b0;
            good_reg   <= 1'b0;
            err_reg    <= '0;
            flen_reg   <= '0;

            case (state_reg)
                ST_IDLE: begin
                    if (mii.mac_mii_rxdv)
                        state_reg <= (mii.mac_mii_rxd == PRE_NIB) ? ST_PREAMBLE : ST_DROP;
                end

                ST_PREAMBLE: begin
                    if (!mii.mac_mii_rxdv) begin
                        state_reg <= ST_IDLE;
                    end else if (mii.mac_mii_rxd == SFD_NIB) begin
                        state_reg <= ST_DATA;
                        phase_reg <= 1'b0;
                        crc_reg   <= CRC_INIT;
                        len_reg   <= '0;
                        rxer_reg  <= 1'b0;
                        fill_reg  <= '0;
                    end else if (mii.mac_mii_rxd != PRE_NIB) begin
                        state_reg <= ST_DROP;
                    end
                end

                ST_DROP: begin
                    if (!mii.mac_mii_rxdv) state_reg <= ST_IDLE;
                end

                ST_DATA: begin
                    if (!mii.mac_mii_rxdv) begin
                        state_reg <= ST_IDLE;
                        done_reg  <= 1'b1;
                        good_reg  <= (err_next == 4'd0);
                        err_reg   <= err_next;
                        flen_reg  <= len_reg;
                        fill_reg  <= '0;
                        phase_reg <= 1'b0;
                        if (line_full) begin
                            tvalid_reg <= 1'b1;
                            tdata_reg  <= dl_reg[DEPTH-1];
                            tlast_reg  <= 1'b1;
                            tuser_reg  <= |err_next;
                        end
                    end else begin
                        if (mii.mac_mii_rxer) rxer_reg <= 1'b1;
                        phase_reg <= ~phase_reg;
                        if (!phase_reg) begin
                            low_nib_reg <= mii.mac_mii_rxd;
                        end else begin
                            crc_reg <= crc_next;
                            if (len_reg != LEN_SAT) len_reg <= len_reg + 11'd1;
                            if (line_full) begin
                                tvalid_reg <= 1'b1;
                                tdata_reg  <= dl_reg[DEPTH-1];
                            end else begin
                                fill_reg <= fill_reg + 3'd1;
                            end
                        end
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign rx.rx_tvalid  = tvalid_reg;
    assign rx.rx_tdata   = tdata_reg;
    assign rx.rx_tlast   = tlast_reg;
    assign rx.rx_tuser   = tuser_reg;
    assign rx.frame_done = done_reg;
    assign rx.frame_good = good_reg;
    assign rx.err_flags  = err_reg;
    assign rx.frame_len  = flen_reg;

endmodule
